// File: rtl/can_arb_engine_if.sv
// rtl/can_arb_engine_if.sv - request/result bundle between request front-ends and the arbitration engine
interface can_arb_engine_if #(
  parameter int N     = 4,
  parameter int ID_W  = 11,
  parameter int IDX_W = $clog2(N),
  parameter int BI_W  = (ID_W > 1) ? $clog2(ID_W) : 1
);
  logic              start;
  logic [N-1:0]      req;
  logic [N*ID_W-1:0] id;
  logic              busy;
  logic              done;
  logic              bus_bit;
  logic [BI_W-1:0]   bit_idx;
  logic [N-1:0]      active;
  logic              winner_valid;
  logic [IDX_W-1:0]  winner_idx;
  logic [ID_W-1:0]   winner_id;
  logic              collision;

  modport master (
    output start, req, id,
    input  busy, done, bus_bit, bit_idx, active,
    input  winner_valid, winner_idx, winner_id, collision
  );

  modport slave (
    input  start, req, id,
    output busy, done, bus_bit, bit_idx, active,
    output winner_valid, winner_idx, winner_id, collision
  );
endinterface

// File: rtl/can_arb_engine.sv
// rtl/can_arb_engine.sv - bit-serial wired-AND CAN arbitration, MSB first, lowest ID wins
// Optional duplicate-winner detection built when ARB_TIE_DETECT_EN is defined.
module can_arb_engine #(
  parameter int N     = 4,
  parameter int ID_W  = 11,
  parameter int IDX_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  can_arb_engine_if.slave bus
);
  localparam int BI_W = (ID_W > 1) ? $clog2(ID_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_shadow [N];
  logic [N-1:0]     r_active, w_active_nxt, w_bits;
  logic [BI_W-1:0]  r_bit_idx;
  logic             w_bus_bit;
  logic             w_accept, w_empty, w_last_bit;
  logic             r_valid;
  logic [IDX_W-1:0] r_win_idx, w_win_idx;
  logic [ID_W-1:0]  r_win_id, w_win_id;

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_empty    = (bus.req == '0);
  assign w_last_bit = (r_bit_idx == '0);

  always_comb begin
    w_bits = '0;
    for (int i = 0; i < N; i++)
      w_bits[i] = r_shadow[i][r_bit_idx];
  end

  // Bus idles recessive; in ARB any surviving node driving 0 pulls it dominant.
  always_comb begin
    w_bus_bit = 1'b1;
    if (r_state == S_ARB) begin
      for (int i = 0; i < N; i++)
        if (r_active[i] && !w_bits[i])
          w_bus_bit = 1'b0;
    end
  end

  assign w_active_nxt = r_active & (~w_bits | {N{w_bus_bit}});

  always_comb begin
    w_win_idx = '0;
    w_win_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_active_nxt[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_id  = r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_empty ? S_DONE : S_ARB;
      S_ARB:  if (w_last_bit) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow IDs are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (w_accept && !w_empty) begin
      for (int i = 0; i < N; i++)
        r_shadow[i] <= bus.id[i*ID_W +: ID_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= '0;
      r_bit_idx <= BI_W'(ID_W - 1);
      r_valid   <= 1'b0;
      r_win_idx <= '0;
      r_win_id  <= '0;
    end else if (w_accept) begin
      r_active  <= bus.req;
      r_bit_idx <= BI_W'(ID_W - 1);
      r_valid   <= 1'b0;
      r_win_idx <= '0;
      r_win_id  <= '0;
    end else if (r_state == S_ARB) begin
      r_active <= w_active_nxt;
      if (w_last_bit) begin
        r_valid   <= 1'b1;
        r_win_idx <= w_win_idx;
        r_win_id  <= w_win_id;
      end else begin
        r_bit_idx <= r_bit_idx - 1'b1;
      end
    end
  end

`ifdef ARB_TIE_DETECT_EN
  logic w_multi;
  logic r_collision;

  always_comb begin
    logic seen;
    seen    = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_active_nxt[i]) begin
        if (seen) w_multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_collision <= 1'b0;
    else if (w_accept)
      r_collision <= 1'b0;
    else if (r_state == S_ARB && w_last_bit)
      r_collision <= w_multi;
  end

  assign bus.collision = r_collision;
`else
  assign bus.collision = 1'b0;
`endif

  assign bus.busy         = (r_state == S_ARB);
  assign bus.done         = (r_state == S_DONE);
  assign bus.bus_bit      = w_bus_bit;
  assign bus.bit_idx      = r_bit_idx;
  assign bus.active       = r_active;
  assign bus.winner_valid = r_valid;
  assign bus.winner_idx   = r_win_idx;
  assign bus.winner_id    = r_win_id;
endmodule

// File: tb/tb_can_arb_engine.sv
// tb/tb_can_arb_engine.sv - scoreboard bench for can_arb_engine (N=4, ID_W=11)
module tb_can_arb_engine;
  logic clk;
  logic rst;

  can_arb_engine_if #(.N(4), .ID_W(11)) u_if ();

  can_arb_engine #(.N(4), .ID_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  idx;
    logic [10:0] id;
    logic        coll;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] act_tr [0:63];
  logic       bus_tr [0:63];
  logic       busy_seen;

`ifdef ARB_TIE_DETECT_EN
  localparam logic TIE_EXP = 1'b1;
`else
  localparam logic TIE_EXP = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic pop_compare(input string name, input int lat);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: done with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, e.lat);
    end
    checks++;
    if (u_if.winner_valid !== e.valid) begin
      errors++; $display("FAIL %s_valid: got %0b expected %0b", name, u_if.winner_valid, e.valid);
    end
    checks++;
    if (u_if.winner_idx !== e.idx) begin
      errors++; $display("FAIL %s_idx: got %0d expected %0d", name, u_if.winner_idx, e.idx);
    end
    checks++;
    if (u_if.winner_id !== e.id) begin
      errors++; $display("FAIL %s_id: got %0h expected %0h", name, u_if.winner_id, e.id);
    end
    checks++;
    if (u_if.collision !== e.coll) begin
      errors++; $display("FAIL %s_collision: got %0b expected %0b", name, u_if.collision, e.coll);
    end
  endtask

  task automatic run_arb(input string name, input logic [3:0] rq, input logic [43:0] ids);
    int e;
    u_if.req   = rq;
    u_if.id    = ids;
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    e = 1;
    busy_seen = u_if.busy;
    act_tr[e] = u_if.active;
    bus_tr[e] = u_if.bus_bit;
    while (!u_if.done && e < 40) begin
      @(posedge clk); #1;
      e++;
      act_tr[e] = u_if.active;
      bus_tr[e] = u_if.bus_bit;
      busy_seen = busy_seen | u_if.busy;
    end
    if (!u_if.done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done within %0d edges", name, e);
      void'(sb.pop_front());
    end else begin
      pop_compare(name, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (u_if.busy !== 1'b0 || u_if.done !== 1'b0 || u_if.winner_valid !== 1'b0 ||
        u_if.winner_idx !== 2'd0 || u_if.winner_id !== 11'd0 || u_if.active !== 4'd0 ||
        u_if.collision !== 1'b0 || u_if.bit_idx !== 4'd10 || u_if.bus_bit !== 1'b1) begin
      errors++;
      $display("FAIL %s: busy=%0b done=%0b valid=%0b idx=%0d id=%0h act=%0b coll=%0b bit_idx=%0d bus=%0b expected all 0 with bit_idx=10 bus=1",
               name, u_if.busy, u_if.done, u_if.winner_valid, u_if.winner_idx, u_if.winner_id,
               u_if.active, u_if.collision, u_if.bit_idx, u_if.bus_bit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.start = 1'b0;
    u_if.req = '0;
    u_if.id = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("after_reset_idle");
  endtask

  task automatic test_basic();
    sb.push_back('{valid: 1'b1, idx: 2'd1, id: 11'h0F0, coll: 1'b0, lat: 12});
    run_arb("basic", 4'b1111, {11'h7FF, 11'h456, 11'h0F0, 11'h123});
    checks++;
    if (act_tr[1] !== 4'b1111) begin
      errors++; $display("FAIL basic_active_start: got %0b expected 1111", act_tr[1]);
    end
    checks++;
    if (act_tr[2] !== 4'b0011) begin
      errors++; $display("FAIL basic_active_bit10: got %0b expected 0011", act_tr[2]);
    end
    checks++;
    if (act_tr[4] !== 4'b0010) begin
      errors++; $display("FAIL basic_active_bit8: got %0b expected 0010", act_tr[4]);
    end
  endtask

  task automatic test_single();
    logic [10:0] obs;
    sb.push_back('{valid: 1'b1, idx: 2'd2, id: 11'h555, coll: 1'b0, lat: 12});
    run_arb("single", 4'b0100, {11'h7FF, 11'h555, 11'h000, 11'h000});
    for (int e = 1; e <= 11; e++) obs[11 - e] = bus_tr[e];
    checks++;
    if (obs !== 11'h555) begin
      errors++; $display("FAIL single_bus_trace: got %0h expected 555", obs);
    end
  endtask

  task automatic test_empty();
    sb.push_back('{valid: 1'b0, idx: 2'd0, id: 11'h000, coll: 1'b0, lat: 1});
    run_arb("empty", 4'b0000, {11'h001, 11'h002, 11'h003, 11'h004});
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++; $display("FAIL empty_busy: got %0b expected 0", busy_seen);
    end
  endtask

  task automatic test_tie();
    sb.push_back('{valid: 1'b1, idx: 2'd1, id: 11'h010, coll: TIE_EXP, lat: 12});
    run_arb("tie", 4'b1010, {11'h010, 11'h000, 11'h010, 11'h000});
    checks++;
    if (act_tr[12] !== 4'b1010) begin
      errors++; $display("FAIL tie_final_active: got %0b expected 1010", act_tr[12]);
    end
  endtask

  task automatic test_midop_change();
    int e;
    int done_cnt;
    int done_edge;
    sb.push_back('{valid: 1'b1, idx: 2'd1, id: 11'h0F0, coll: 1'b0, lat: 12});
    u_if.req   = 4'b1111;
    u_if.id    = {11'h7FF, 11'h456, 11'h0F0, 11'h123};
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    e = 1;
    done_cnt = 0;
    done_edge = 0;
    while (e < 30) begin
      if (e == 6) begin
        u_if.req   = 4'b1000;
        u_if.id    = {11'h000, 11'h7FF, 11'h7FF, 11'h7FF};
        u_if.start = 1'b1;
      end else if (e == 7) begin
        u_if.start = 1'b0;
      end
      @(posedge clk); #1;
      e++;
      if (u_if.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_edge = e;
          pop_compare("midop", e);
        end
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL midop_done_count: got %0d expected 1 (first at edge %0d)", done_cnt, done_edge);
    end
    if (done_cnt == 0) void'(sb.pop_front());
  endtask

  task automatic test_reset_midop();
    int e;
    int done_cnt;
    u_if.req   = 4'b1111;
    u_if.id    = {11'h7FF, 11'h456, 11'h0F0, 11'h123};
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    for (e = 1; e < 5; e++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (u_if.bit_idx !== 4'd6) begin
      errors++; $display("FAIL rstmid_bit_idx: got %0d expected 6", u_if.bit_idx);
    end
    rst = 1'b1;
    #1;
    check_reset_values("rstmid_async");
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (u_if.done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt);
    end
    test_single();
  endtask

  initial begin
    rst = 1'b1;
    u_if.start = 1'b0;
    u_if.req = '0;
    u_if.id = '0;
    test_reset();
    test_basic();
    test_single();
    test_empty();
    test_tie();
    test_midop_change();
    test_reset_midop();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
